fpga2_rx_checker: RTL and testbench
===================================

// Module: fpga2_rx_checker
// PURPOSE
//  Receive end of the fpga1->fpga2 32-bit req/ack/rdy link, with self-checking.
//  Accepts words from the fpga1 sender over a 4-phase handshake and synchronises req_in.
//  Compares each word against the sender's decrementing test pattern.
//  Counts words and errors; drives pass/done status (LED) once RECEIVE_COUNT words have arrived.
// PARAMETERS
//  RECEIVE_COUNT  100           words to accept before done; must be >= 1
//  EXP_INIT       32'hFFFFFFFE  expected value of the first word; each later word expects previous-1
//  TIMEOUT_CYCLES 1024          watchdog limit; used only with F2F_RX_TIMEOUT_EN
// PORTS
//  clk        in   1   single system clock
//  rst        in   1   asynchronous, active-low reset
//  data_in    in   32  link data from sender; stable whenever req_in=1
//  req_in     in   1   sender request (asynchronous to clk)
//  rdy_out    out  1   receiver ready to accept a word
//  ack_out    out  1   word captured acknowledge
//  data_out   out  32  last captured word
//  data_vld   out  1   1-cycle pulse: data_out updated
//  word_cnt   out  $clog2(RECEIVE_COUNT+1)  words accepted
//  err_cnt    out  16  mismatching words, saturates at 16'hFFFF
//  first_err  out  32  first mismatching word received (0 if none)
//  done       out  1   RECEIVE_COUNT words accepted (sticky)
//  pass       out  1   done && err_cnt==0 (LED drive)
//  timeout    out  1   watchdog fired (sticky); constant 0 without F2F_RX_TIMEOUT_EN
// BEHAVIOUR
//  Reset (rst=0, async): state=WAIT_LOW; all outputs 0; expected register = EXP_INIT; sync flops = 0.
//  req_in passes through a 2-flop synchroniser (req_s2). data_in is sampled directly; it is stable under req.
//  FSM:
//  - WAIT_LOW: rdy_out=0. Go to IDLE when req_s2=0, so a req held high across reset is never taken as a word.
//  - IDLE: rdy_out=1. req_s2=1 -> CAPTURE.
//  - CAPTURE (1 cycle): latch data_out<=data_in; ack_out<=1; data_vld pulse; word_cnt+1.
//    On mismatch: err_cnt+1 (saturating); the first mismatch loads first_err.
//    Expected value <= expected-1, computed modulo 2^32, so 0 wraps to FFFFFFFF.
//    Next state is ACK.
//  - ACK: ack_out=1, rdy_out=0. req_s2=0 -> drop ack_out.
//    Then go to DONE if word_cnt==RECEIVE_COUNT, else IDLE.
//  - DONE: terminal. rdy_out=0, ack_out=0, done=1, pass=(err_cnt==0). Further reqs are ignored (never acked).
//  Latency: req_in rising before clk edge N -> ack_out=1 and data_out valid after edge N+2.
//  After req_in falls, ack_out falls 3 edges later.
//  Minimum spacing is 6 clk per word.
//  data_vld and the counter updates occur in the same cycle; pass is never 1 while done=0.
//  Reset mid-handshake: ack_out drops immediately. The sender sees no ack and re-drives req.
//  Because of WAIT_LOW, a word in flight during reset is not double-counted.
// CONFIGURATION
//  F2F_RX_TIMEOUT_EN defined: a cycle counter runs in IDLE (when word_cnt>0) and in ACK. It clears on each transition.
//    When it reaches TIMEOUT_CYCLES: timeout=1 (sticky), ack_out=0, state=DONE, pass=0.
//  F2F_RX_TIMEOUT_EN undefined: no watchdog logic; timeout tied 0; the FSM can wait forever.
// TESTING
//  T1: RECEIVE_COUNT=4; send FFFFFFFE,FFFFFFFD,FFFFFFFC,FFFFFFFB -> word_cnt=4, err_cnt=0, done=1, pass=1, first_err=0.
//  T2: RECEIVE_COUNT=4; 2nd word 12345678 -> err_cnt=1, first_err=12345678, pass=0, done=1.
//      The expected value still advances: word 3 = FFFFFFFC counts as OK.
//  T3: EXP_INIT=1; send 1,0,FFFFFFFF -> err_cnt=0 (wrap-around passes).
//  T4: req_in held 1 through reset release -> no ack_out, word_cnt=0 until req_in goes low then high.
//  T5: assert rst while ack_out=1 -> ack_out=0 in the same cycle; all counters 0.
//      After release, the re-sent word is counted once.
//  T6 (F2F_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16): hold req_in=1 after ack -> timeout=1 and ack_out=0 after 16 cycles in ACK; pass=0.

Source files
------------

// File: rtl/fpga2_rx_checker_if.sv
// rtl/fpga2_rx_checker_if.sv - fpga1->fpga2 32-bit req/ack/rdy link interface
//
// Purpose: groups the four link signals between the fpga1 sender (master)
//          and the fpga2 receiver/checker (slave).
// Signals:
//   data_in  32  link data, stable whenever req_in=1   (master -> slave)
//   req_in    1  sender request, asynchronous to clk   (master -> slave)
//   rdy_out   1  receiver ready to accept a word       (slave -> master)
//   ack_out   1  word captured acknowledge             (slave -> master)
interface fpga2_rx_checker_if;
  logic [31:0] data_in;
  logic        req_in;
  logic        rdy_out;
  logic        ack_out;

  modport master (output data_in, output req_in, input rdy_out, input ack_out);
  modport slave  (input data_in, input req_in, output rdy_out, output ack_out);
endinterface

// File: rtl/fpga2_rx_checker.sv
// rtl/fpga2_rx_checker.sv - fpga2 receive end of the fpga1->fpga2 link with pattern self-check
//
// Purpose: accepts words over a 4-phase req/ack handshake (req synchronised
//          through two flops), checks each word against the sender's
//          decrementing pattern, and reports counts plus done/pass status.
// Optional feature: define F2F_RX_TIMEOUT_EN to build the watchdog that forces
//          DONE with timeout=1 after TIMEOUT_CYCLES idle cycles mid-transfer.
// Ports:
//   i_clk         in   1   system clock
//   i_rst         in   1   asynchronous, active-low reset
//   link          slave    data_in / req_in / rdy_out / ack_out
//   o_data_out    out  32  last captured word
//   o_data_vld    out  1   one-cycle pulse when o_data_out updates
//   o_word_cnt    out  $clog2(RECEIVE_COUNT+1) words accepted
//   o_err_cnt     out  16  mismatching words, saturating
//   o_first_err   out  32  first mismatching word (0 if none)
//   o_done        out  1   RECEIVE_COUNT words accepted (sticky)
//   o_pass        out  1   done with zero errors
//   o_timeout     out  1   watchdog fired (sticky), 0 when watchdog not built
module fpga2_rx_checker #(
  parameter int          RECEIVE_COUNT  = 100,
  parameter logic [31:0] EXP_INIT       = 32'hFFFF_FFFE,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  fpga2_rx_checker_if.slave                    link,
  output logic [31:0]                          o_data_out,
  output logic                                 o_data_vld,
  output logic [$clog2(RECEIVE_COUNT+1)-1:0]   o_word_cnt,
  output logic [15:0]                          o_err_cnt,
  output logic [31:0]                          o_first_err,
  output logic                                 o_done,
  output logic                                 o_pass,
  output logic                                 o_timeout
);
  localparam int CW = $clog2(RECEIVE_COUNT + 1);

  typedef enum logic [2:0] {S_WAIT_LOW, S_IDLE, S_CAPTURE, S_ACK, S_DONE} state_t;

  state_t        r_state;
  logic          r_req_s1, r_req_s2;
  logic [1:0]    r_prime;
  logic [31:0]   r_exp;
  logic [31:0]   r_data;
  logic          r_vld, r_rdy, r_ack, r_done, r_pass;
  logic [CW-1:0] r_word_cnt;
  logic [15:0]   r_err_cnt;
  logic [31:0]   r_first_err;

  logic w_mismatch;
  logic w_last;
  assign w_mismatch = (link.data_in != r_exp);
  assign w_last     = (r_word_cnt == CW'(RECEIVE_COUNT));

`ifdef F2F_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wd;
  logic          r_timeout;
  logic          w_wd_run, w_leave, w_wd_fire;
  assign w_wd_run  = (r_state == S_ACK) || ((r_state == S_IDLE) && (r_word_cnt != '0));
  // A state transition in this cycle restarts the count and wins over firing.
  assign w_leave   = ((r_state == S_IDLE) && r_req_s2) || ((r_state == S_ACK) && !r_req_s2);
  assign w_wd_fire = w_wd_run && !w_leave && (r_wd == TW'(TIMEOUT_CYCLES - 1));
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_WAIT_LOW;
      r_req_s1    <= 1'b0;
      r_req_s2    <= 1'b0;
      r_prime     <= 2'd0;
      r_exp       <= EXP_INIT;
      r_data      <= '0;
      r_vld       <= 1'b0;
      r_rdy       <= 1'b0;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_word_cnt  <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
`ifdef F2F_RX_TIMEOUT_EN
      r_wd        <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_req_s1 <= link.req_in;
      r_req_s2 <= r_req_s1;
      r_vld    <= 1'b0;
`ifdef F2F_RX_TIMEOUT_EN
      if (!w_wd_run || w_leave) r_wd <= '0;
      else                      r_wd <= r_wd + 1'b1;

      if (w_wd_fire) begin
        r_timeout <= 1'b1;
        r_ack     <= 1'b0;
        r_rdy     <= 1'b0;
        r_done    <= 1'b1;
        r_pass    <= 1'b0;
        r_state   <= S_DONE;
      end else
`endif
      begin
        case (r_state)
          // The synchroniser still holds its reset zeros for two edges, so
          // req_s2 only reflects the real line from the third edge on; wait
          // for that before trusting req_s2=0.
          S_WAIT_LOW: begin
            r_rdy <= 1'b0;
            if (r_prime != 2'd2) begin
              r_prime <= r_prime + 2'd1;
            end else if (!r_req_s2) begin
              r_state <= S_IDLE;
              r_rdy   <= 1'b1;
            end
          end
          // Capture work is registered on the edge entering CAPTURE so that
          // ack/data_out appear two edges after req_in is first sampled.
          S_IDLE: begin
            if (r_req_s2) begin
              r_state    <= S_CAPTURE;
              r_rdy      <= 1'b0;
              r_data     <= link.data_in;
              r_ack      <= 1'b1;
              r_vld      <= 1'b1;
              r_word_cnt <= r_word_cnt + 1'b1;
              r_exp      <= r_exp - 32'd1;
              if (w_mismatch) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                if (r_err_cnt == 16'd0)    r_first_err <= link.data_in;
              end
            end
          end
          S_CAPTURE: r_state <= S_ACK;
          S_ACK: begin
            if (!r_req_s2) begin
              r_ack <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_pass  <= (r_err_cnt == 16'd0);
              end else begin
                r_state <= S_IDLE;
                r_rdy   <= 1'b1;
              end
            end
          end
          S_DONE:  r_state <= S_DONE;
          default: r_state <= S_WAIT_LOW;
        endcase
      end
    end
  end

  assign link.rdy_out = r_rdy;
  assign link.ack_out = r_ack;
  assign o_data_out   = r_data;
  assign o_data_vld   = r_vld;
  assign o_word_cnt   = r_word_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_first_err  = r_first_err;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
endmodule

// File: tb/tb_fpga2_rx_checker.sv
// tb/tb_fpga2_rx_checker.sv - scoreboard bench for fpga2_rx_checker with randomized pattern errors
module tb_fpga2_rx_checker;
  localparam int          RC = 6;
  localparam logic [31:0] EI = 32'h0000_0002;
  localparam int          CW = $clog2(RC + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpga2_rx_checker_if link();

  logic [31:0]   o_data_out;
  logic          o_data_vld;
  logic [CW-1:0] o_word_cnt;
  logic [15:0]   o_err_cnt;
  logic [31:0]   o_first_err;
  logic          o_done, o_pass, o_timeout;

  fpga2_rx_checker #(.RECEIVE_COUNT(RC), .EXP_INIT(EI), .TIMEOUT_CYCLES(1024)) dut (
    .i_clk(clk), .i_rst(rst), .link(link),
    .o_data_out(o_data_out), .o_data_vld(o_data_vld), .o_word_cnt(o_word_cnt),
    .o_err_cnt(o_err_cnt), .o_first_err(o_first_err), .o_done(o_done),
    .o_pass(o_pass), .o_timeout(o_timeout)
  );

  typedef struct {
    logic [31:0] data;
    int          wcnt;
    int          ecnt;
    logic [31:0] ferr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: word k after reset should equal EI - k (mod 2^32).
  int          m_words;
  int          m_errs;
  logic [31:0] m_first;

  function automatic logic [31:0] model_exp(input int k);
    return EI - 32'(k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_words = 0;
    m_errs  = 0;
    m_first = '0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (o_data_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_data_vld", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("data_out", o_data_out, mon_e.data);
        chk("word_cnt_at_vld", o_word_cnt, mon_e.wcnt);
        chk("err_cnt_at_vld", o_err_cnt, mon_e.ecnt);
        chk("first_err_at_vld", o_first_err, mon_e.ferr);
      end
    end
    if (o_pass) chk("pass_implies_done", o_done, 1);
  end

  task automatic req_up(input logic [31:0] d);
    int   n;
    exp_t e;
    n = 0;
    while (!link.rdy_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_before_send", link.rdy_out, 1);
    if (d !== model_exp(m_words)) begin
      if (m_errs == 0) m_first = d;
      if (m_errs < 65535) m_errs++;
    end
    m_words++;
    e.data = d; e.wcnt = m_words; e.ecnt = m_errs; e.ferr = m_first;
    sb.push_back(e);
    #1;
    link.data_in = d;
    link.req_in  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!link.ack_out && n < 20);
    chk("ack_rise_latency", n, 3);
  endtask

  task automatic req_down();
    int n;
    #1;
    link.req_in = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (link.ack_out && n < 20);
    chk("ack_fall_latency", n, 3);
  endtask

  task automatic send(input logic [31:0] d);
    req_up(d);
    req_down();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_final(input string tag);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_pass"}, o_pass, (m_errs == 0));
    chk({tag, "_word_cnt"}, o_word_cnt, RC);
    chk({tag, "_err_cnt"}, o_err_cnt, m_errs);
    chk({tag, "_first_err"}, o_first_err, m_first);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    logic [31:0] d;
    int          bad_seen;
    link.req_in  = 1'b0;
    link.data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rdy", link.rdy_out, 0);
    chk("rst_ack", link.ack_out, 0);
    chk("rst_vld", o_data_vld, 0);
    chk("rst_data_out", o_data_out, 0);
    chk("rst_word_cnt", o_word_cnt, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    chk("rst_first_err", o_first_err, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pass", o_pass, 0);
    chk("rst_timeout", o_timeout, 0);
    #1 rst = 1'b1;

    // Clean run: pattern crosses 0 -> FFFFFFFF, which must still pass.
    for (int k = 0; k < RC; k++) begin
      chk("done_early_clean", o_done, 0);
      send(model_exp(m_words));
    end
    @(negedge clk);
    check_final("clean");

    // DONE ignores further requests.
    #1 link.req_in = 1'b1;
    bad_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (link.ack_out) bad_seen = 1;
    end
    chk("done_ignores_req_ack", bad_seen, 0);
    chk("done_ignores_req_cnt", o_word_cnt, RC);
    #1 link.req_in = 1'b0;

    // Randomized corruption; word 1 always corrupted.
    apply_reset();
    for (int k = 0; k < RC; k++) begin
      d = model_exp(m_words);
      if (k == 1 || $urandom_range(0, 3) == 0) d = d ^ ($urandom() | 32'h1);
      send(d);
    end
    @(negedge clk);
    check_final("rand");

    // req held high across reset release is not taken as a word.
    rst = 1'b0;
    model_reset();
    link.data_in = EI;
    link.req_in  = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    bad_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (link.ack_out) bad_seen = 1;
    end
    chk("held_req_no_ack", bad_seen, 0);
    chk("held_req_word_cnt", o_word_cnt, 0);
    chk("held_req_rdy", link.rdy_out, 0);
    #1 link.req_in = 1'b0;
    send(model_exp(m_words));
    @(negedge clk);
    chk("after_held_word_cnt", o_word_cnt, 1);

    // Reset while ack is high.
    req_up(model_exp(m_words));
    chk("pre_reset_ack", link.ack_out, 1);
    #1 rst = 1'b0;
    #1;
    chk("reset_ack_drop", link.ack_out, 0);
    chk("reset_word_cnt", o_word_cnt, 0);
    chk("reset_err_cnt", o_err_cnt, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("inflight_not_recounted", o_word_cnt, 0);
    #1 link.req_in = 1'b0;
    send(model_exp(m_words));
    @(negedge clk);
    chk("resent_word_cnt", o_word_cnt, 1);
    chk("resent_err_cnt", o_err_cnt, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
